// File: rtl/display7_scan.sv
// Time-multiplexed common-anode seven-segment driver for DIGITS digits sharing one segment bus.
// Hex/BCD decode, per-digit blanking and decimal points, and optional leading-zero suppression.
module display7_scan #(
    parameter int DIGITS     = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   iData,
    input  logic [DIGITS-1:0]     iDp,
    input  logic [DIGITS-1:0]     iBlank,
    input  logic                  iMode,
    input  logic                  iLeadZero,
    output logic [6:0]            oSeg,
    output logic                  oDp,
    output logic [DIGITS-1:0]     oAn
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic POL = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    nextIdx;
    logic                tick;
    logic                frameStart;

    logic [4*DIGITS-1:0] snapData;
    logic [DIGITS-1:0]   snapDp;
    logic [DIGITS-1:0]   snapBlank;
    logic                snapMode;
    logic                snapLeadZero;

    logic [4*DIGITS-1:0] srcData;
    logic [DIGITS-1:0]   srcDp;
    logic [DIGITS-1:0]   srcBlank;
    logic                srcMode;
    logic                srcLeadZero;

    logic [3:0]          nib;
    logic                zeroRun;
    logic                lzHit;
    logic                dark;
    logic [6:0]          segOn;
    logic                dpOn;
    logic [DIGITS-1:0]   anOn;

    // Prescaler and digit index
    assign tick       = (cnt == CNT_LAST);
    assign nextIdx    = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    assign frameStart = tick && (nextIdx == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= IDX_LAST;
        end else begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
            if (tick) begin
                idx <= nextIdx;
            end
        end
    end

    // Frame snapshot: held for digits 1..DIGITS-1 so a frame never mixes two input values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snapData     <= '0;
            snapDp       <= '0;
            snapBlank    <= '0;
            snapMode     <= 1'b0;
            snapLeadZero <= 1'b0;
        end else if (frameStart) begin
            snapData     <= iData;
            snapDp       <= iDp;
            snapBlank    <= iBlank;
            snapMode     <= iMode;
            snapLeadZero <= iLeadZero;
        end
    end

    // Digit 0 decodes from the live inputs being captured on the same edge
    always_comb begin
        if (nextIdx == '0) begin
            srcData     = iData;
            srcDp       = iDp;
            srcBlank    = iBlank;
            srcMode     = iMode;
            srcLeadZero = iLeadZero;
        end else begin
            srcData     = snapData;
            srcDp       = snapDp;
            srcBlank    = snapBlank;
            srcMode     = snapMode;
            srcLeadZero = snapLeadZero;
        end
    end

    // Decode the digit about to be lit
    always_comb begin
        nib     = srcData[4*int'(nextIdx) +: 4];
        zeroRun = 1'b1;
        lzHit   = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zeroRun = zeroRun & (srcData[4*k +: 4] == 4'h0);
            if (IDX_W'(k) == nextIdx) begin
                lzHit = zeroRun;
            end
        end
        dark  = srcBlank[nextIdx]
              | (srcMode && (nib > 4'd9))
              | (srcLeadZero && (nextIdx != '0) && lzHit);
        segOn = dark ? 7'h00 : hexToSeg(nib);
        dpOn  = srcDp[nextIdx] & ~dark;
        anOn  = DIGITS'(1) << nextIdx;
    end

    // Output register: all pins change together on the tick edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oSeg <= {7{POL}};
            oDp  <= POL;
            oAn  <= {DIGITS{POL}};
        end else if (tick) begin
            oSeg <= segOn ^ {7{POL}};
            oDp  <= dpOn ^ POL;
            oAn  <= anOn ^ {DIGITS{POL}};
        end
    end

endmodule
